alu_issue: RTL

- Issue stage directly upstream of the combinational MIPS ALU.
- Accepts one instruction word plus its register operand values per handshake, then decodes it into ALU controls: AS, AO, LO and SRO.
- Selects and extends operands A and B.
- Buffers decoded operations in a small FIFO with valid/ready on both sides, so the ALU/writeback side can stall without losing ops.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_decode.sv | 115 +++++++++++
 rtl/alu_issue.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and entry layout for the ALU issue stage.
// ALU_ISSUE_OVTRAP_EN adds the per-entry overflow-trap bit.
package alu_pkg;

    localparam logic [3:0] AS_ARITH = 4'd0;
    localparam logic [3:0] AS_LOGIC = 4'd1;
    localparam logic [3:0] AS_SHIFT = 4'd2;
    localparam logic [3:0] AS_PASS  = 4'd3;

    localparam logic [1:0] AO_ADD = 2'd0;
    localparam logic [1:0] AO_SUB = 2'd1;

    localparam logic [3:0] LO_AND = 4'd0;
    localparam logic [3:0] LO_OR  = 4'd1;
    localparam logic [3:0] LO_XOR = 4'd2;
    localparam logic [3:0] LO_NOR = 4'd3;

    localparam logic [3:0] SRO_SLL  = 4'd0;
    localparam logic [3:0] SRO_SRL  = 4'd1;
    localparam logic [3:0] SRO_SRA  = 4'd2;
    localparam logic [3:0] SRO_ROTR = 4'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    // Entry = {A, B, AS, AO, LO, SRO, ILL[, OVT]}
`ifdef ALU_ISSUE_OVTRAP_EN
    localparam int CTL_W = 16;
`else
    localparam int CTL_W = 15;
`endif

    function automatic int entry_w(input int width);
        return 2 * width + CTL_W;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS instruction decode into ALU controls and operands.
// ALU_ISSUE_OVTRAP_EN adds the ovt output.
module alu_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       sec,
    output logic [1:0]       arith_op,
    output logic [3:0]       logic_op,
    output logic [3:0]       shift_op,
`ifdef ALU_ISSUE_OVTRAP_EN
    output logic             ovt,
`endif
    output logic             ill
);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [15:0]      imm;
    logic [WIDTH-1:0] shamt_ext;
    logic [WIDTH-1:0] rsamt_ext;
    logic [WIDTH-1:0] simm;
    logic [WIDTH-1:0] zimm;
    logic [WIDTH-1:0] uimm;
    logic             unused;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign imm       = instr[15:0];
    assign shamt_ext = WIDTH'(instr[10:6]);
    assign rsamt_ext = WIDTH'(rs_val[4:0]);
    assign simm      = WIDTH'($signed(imm));
    assign zimm      = WIDTH'(imm);
    assign uimm      = WIDTH'({imm, 16'h0000});
    // Register-number fields are resolved upstream; only the values matter here.
    assign unused    = ^{instr[25:22], instr[20:16]};

    always_comb begin
        a        = '0;
        b        = '0;
        sec      = AS_ARITH;
        arith_op = AO_ADD;
        logic_op = LO_AND;
        shift_op = SRO_SLL;
        ill      = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    F_ADD, F_ADDU: begin
                        a = rs_val;
                        b = rt_val;
                    end
                    F_SUB, F_SUBU: begin
                        arith_op = AO_SUB;
                        a        = rs_val;
                        b        = rt_val;
                    end
                    F_AND, F_OR, F_XOR, F_NOR: begin
                        sec      = AS_LOGIC;
                        logic_op = {2'b00, funct[1:0]};
                        a        = rs_val;
                        b        = rt_val;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        sec = AS_SHIFT;
                        a   = shamt_ext;
                        b   = rt_val;
                        if (funct == F_SRA)
                            shift_op = SRO_SRA;
                        else if (funct == F_SRL)
                            shift_op = instr[21] ? SRO_ROTR : SRO_SRL;
                    end
                    F_SLLV, F_SRLV, F_SRAV: begin
                        sec = AS_SHIFT;
                        a   = rsamt_ext;
                        b   = rt_val;
                        if (funct == F_SRAV)
                            shift_op = SRO_SRA;
                        else if (funct == F_SRLV)
                            shift_op = instr[6] ? SRO_ROTR : SRO_SRL;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                a = rs_val;
                b = simm;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                sec      = AS_LOGIC;
                logic_op = {2'b00, opcode[1:0]};
                a        = rs_val;
                b        = zimm;
            end
            OP_LUI: begin
                sec = AS_PASS;
                b   = uimm;
            end
            default: ill = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_OVTRAP_EN
    assign ovt = (opcode == OP_ADDI) ||
                 ((opcode == OP_RTYPE) &&
                  ((funct == F_ADD) || (funct == F_SUB)));
`endif

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes one instruction per handshake into a small op FIFO.
// ALU_ISSUE_OVTRAP_EN adds the queued OVT output.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTR,
    input  logic [WIDTH-1:0] RS_VAL,
    input  logic [WIDTH-1:0] RT_VAL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       AS,
    output logic [1:0]       AO,
    output logic [3:0]       LO,
    output logic [3:0]       SRO,
`ifdef ALU_ISSUE_OVTRAP_EN
    output logic             OVT,
`endif
    output logic             ILL
);

    localparam int EW = entry_w(WIDTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [EW-1:0]    din;
    logic [EW-1:0]    head;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] d_a;
    logic [WIDTH-1:0] d_b;
    logic [3:0]       d_sec;
    logic [1:0]       d_ao;
    logic [3:0]       d_lo;
    logic [3:0]       d_sro;
    logic             d_ill;

`ifdef ALU_ISSUE_OVTRAP_EN
    logic             d_ovt;
`endif

    alu_decode #(.WIDTH(WIDTH)) u_decode (
        .instr    (INSTR),
        .rs_val   (RS_VAL),
        .rt_val   (RT_VAL),
        .a        (d_a),
        .b        (d_b),
        .sec      (d_sec),
        .arith_op (d_ao),
        .logic_op (d_lo),
        .shift_op (d_sro),
`ifdef ALU_ISSUE_OVTRAP_EN
        .ovt      (d_ovt),
`endif
        .ill      (d_ill)
    );

`ifdef ALU_ISSUE_OVTRAP_EN
    assign din = {d_a, d_b, d_sec, d_ao, d_lo, d_sro, d_ill, d_ovt};
`else
    assign din = {d_a, d_b, d_sec, d_ao, d_lo, d_sro, d_ill};
`endif

    assign IN_READY  = (count < FULL);
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK) begin
        if (push && !FLUSH && !RST)
            mem[wr_ptr] <= din;
    end

    // RST outranks FLUSH; both discard any same-cycle push or pop.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = OUT_VALID ? mem[rd_ptr] : '0;

`ifdef ALU_ISSUE_OVTRAP_EN
    assign {A, B, AS, AO, LO, SRO, ILL, OVT} = head;
`else
    assign {A, B, AS, AO, LO, SRO, ILL} = head;
`endif

endmodule
